// File: rtl/dpram_bwe_clr.sv
`default_nettype none
// ============================================================================
//  Module      : dpram_bwe_clr
//  Description : Simple dual-port RAM (one read, one write port) with byte
//                write enables, registered read data, selectable write-first
//                or read-first collision behaviour, and a self-timed clear
//                sweep that zeroes the whole array one word per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module dpram_bwe_clr #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     raddr,
    input  logic                  re,
    output logic [DATA_W-1:0]     dataout,
    output logic                  rvalid,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     datain,
    input  logic [DATA_W/8-1:0]   wbe,
    input  logic                  we,
    input  logic                  clear,
    output logic                  busy
);

    localparam int NBYTES = DATA_W / 8;
    localparam int DEPTH  = 2 ** ADDR_W;

    localparam logic [0:0]        c_IDLE  = 1'b0;
    localparam logic [0:0]        c_CLEAR = 1'b1;
    localparam logic [ADDR_W-1:0] c_LAST  = '1;

    logic [0:0]          r_state;
    logic [ADDR_W-1:0]   r_cnt;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_wr_act;
    logic                w_rd_act;
    logic                w_mem_en;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [NBYTES-1:0]   w_mem_be;
    logic [DATA_W-1:0]   w_mem_data;
    logic [DATA_W-1:0]   w_old_word;
    logic [DATA_W-1:0]   w_rd_word;

    // External accesses are only honoured outside a clear sweep.
    assign busy     = (r_state == c_CLEAR);
    assign w_wr_act = we & ~busy;
    assign w_rd_act = re & ~busy;

    // Controller: reset lands in CLEAR so every reset is followed by a full sweep.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_CLEAR;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_cnt <= '0;
                    if (clear) begin
                        r_state <= c_CLEAR;
                    end
                end
                c_CLEAR: begin
                    if (r_cnt == c_LAST) begin
                        r_state <= c_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_CLEAR;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Single write port shared by the sweep (full-word zero) and the user.
    always_comb begin
        w_mem_en   = 1'b0;
        w_mem_addr = waddr;
        w_mem_be   = wbe;
        w_mem_data = datain;
        if (busy) begin
            w_mem_en   = 1'b1;
            w_mem_addr = r_cnt;
            w_mem_be   = '1;
            w_mem_data = '0;
        end else begin
            w_mem_en   = w_wr_act;
        end
    end

    // Array update, byte-lane granular; the array itself carries no reset.
    always_ff @(posedge clk) begin
        if (w_mem_en) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (w_mem_be[b]) begin
                    r_mem[w_mem_addr][b*8 +: 8] <= w_mem_data[b*8 +: 8];
                end
            end
        end
    end

    assign w_old_word = r_mem[raddr];

    generate
        if (BYPASS != 0) begin : g_bypass
            logic [DATA_W-1:0] w_merged;

            // Write-first: forward the enabled bytes of the concurrent write.
            always_comb begin
                w_merged = w_old_word;
                for (int b = 0; b < NBYTES; b++) begin
                    if (wbe[b]) begin
                        w_merged[b*8 +: 8] = datain[b*8 +: 8];
                    end
                end
            end

            assign w_rd_word = (w_wr_act && (raddr == waddr)) ? w_merged : w_old_word;
        end else begin : g_read_first
            assign w_rd_word = w_old_word;
        end
    endgenerate

    // Registered read data; dataout holds when no read is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dataout <= '0;
            rvalid  <= 1'b0;
        end else begin
            rvalid <= w_rd_act;
            if (w_rd_act) begin
                dataout <= w_rd_word;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/dpram_bwe_clr.md
DPRAM_BWE_CLR -- requirements
Module: dpram_bwe_clr

Interface
REQ-001 The parameter DATA_W SHALL default to 32 and is the word width in bits; legal values are multiples of 8 from 8 to 128.
REQ-002 The parameter ADDR_W SHALL default to 5 and is the address width in bits; DEPTH = 2**ADDR_W words.
REQ-003 The parameter BYPASS SHALL default to 1; it selects write-first (1) or read-first (0) behaviour on same-address collisions.
REQ-004 The port clk SHALL be an input, 1 bit wide, and is the single clock; all state changes on its rising edge.
REQ-005 The port reset_n SHALL be an input, 1 bit wide, and is the asynchronous, active-low reset.
REQ-006 The port raddr SHALL be an input, ADDR_W bits wide, and carries the read address.
REQ-007 The port re SHALL be an input, 1 bit wide, and is the read enable.
REQ-008 The port dataout SHALL be an output, DATA_W bits wide, and carries the registered read data.
REQ-009 The port rvalid SHALL be an output, 1 bit wide, and indicates that dataout holds the result of a read accepted on the previous cycle.
REQ-010 The port waddr SHALL be an input, ADDR_W bits wide, and carries the write address.
REQ-011 The port datain SHALL be an input, DATA_W bits wide, and carries the write data.
REQ-012 The port wbe SHALL be an input, DATA_W/8 bits wide, and is the byte write enable; bit i covers datain[8i+7:8i].
REQ-013 The port we SHALL be an input, 1 bit wide, and is the write enable.
REQ-014 The port clear SHALL be an input, 1 bit wide, and is a single-cycle request to zero the whole array.
REQ-015 The port busy SHALL be an output, 1 bit wide, and is high while a clear sweep is in progress.

Function
REQ-016 The write path SHALL update exactly those bytes of mem[waddr] whose wbe bit is 1 when we=1 and busy=0; bytes with wbe=0 SHALL keep their value, and we=1 with wbe=0 SHALL leave the array unchanged.
REQ-017 The read path SHALL, when re=1 and busy=0, load dataout with mem[raddr] on the same edge and set rvalid=1 for exactly the following cycle (read latency 1).
REQ-018 When re=0 or busy=1, dataout SHALL hold its previous value and rvalid SHALL be 0.
REQ-019 On a collision (re=1, we=1, raddr=waddr, busy=0) with BYPASS=1, dataout SHALL equal the old word with the wbe-enabled bytes replaced by datain.
REQ-020 On a collision with BYPASS=0, dataout SHALL equal the old word.
REQ-021 The controller SHALL be an FSM with two states, IDLE and CLEAR, plus an ADDR_W-bit sweep counter.
REQ-022 In CLEAR, the block SHALL write all-zero to mem[counter] each cycle and increment the counter; when the counter equals DEPTH-1, it SHALL write that word, reset the counter to 0 and move to IDLE on the same edge.
REQ-023 A clear sweep SHALL last exactly DEPTH cycles, with busy=1 during those cycles and busy=0 from the next cycle onward.
REQ-024 In IDLE, clear=1 SHALL move the FSM to CLEAR on the next edge; any write or read presented in that same cycle SHALL still be performed.
REQ-025 clear=1 while in CLEAR SHALL be ignored: the sweep does not restart and is not extended.
REQ-026 External we and re SHALL be ignored while busy=1; no write, read or rvalid is produced, and no buffering occurs.
REQ-027 The counter SHALL wrap modulo DEPTH and never address beyond DEPTH-1.

Reset
REQ-028 Asserting reset_n=0 SHALL immediately force state=CLEAR, counter=0, busy=1, rvalid=0 and dataout=0.
REQ-029 After reset_n deasserts, the block SHALL start a full clear sweep automatically; the array contents are undefined until that sweep completes.
REQ-030 A reset asserted in the middle of a sweep SHALL abort it, and after release a complete sweep SHALL restart from address 0.
REQ-031 The memory array SHALL NOT be reset directly; only the sweep zeroes it.

Verification
REQ-032 Scenario: release reset with defaults -> busy=1 for exactly 32 cycles; then reading each of addresses 0..31 -> dataout=0x00000000 with rvalid=1 one cycle after each re.
REQ-033 Scenario: write 0xDEADBEEF with wbe=4'b1111 to address 7, then write 0x11223344 with wbe=4'b0101 to address 7, then read address 7 -> 0xDE22BE44.
REQ-034 Scenario: mem[3]=0xAAAAAAAA, then a same-cycle read and write of address 3 with datain=0x55555555 and wbe=4'b0011 -> dataout=0xAAAA5555 with BYPASS=1 and 0xAAAAAAAA with BYPASS=0; a following read -> 0xAAAA5555.
REQ-035 Scenario: after 5 writes, pulse clear, then assert we and re during busy -> busy=1 for 32 cycles, rvalid stays 0, and all words read 0 afterwards.
REQ-036 Scenario: assert reset_n=0 at sweep cycle 10 for 2 cycles -> busy is held at 1, the sweep restarts, and busy=1 for exactly 32 cycles after release.
REQ-037 Scenario: DATA_W=64, ADDR_W=3 -> the sweep lasts 8 cycles and an 8-bit wbe correctly merges bytes.
